// File: rtl/psc_sweep_ctrl.sv
// Prescaler sweep controller: steps a divider prescale value from a start value toward a stop value,
// holding each value for a programmable number of divider output periods.
module psc_sweep_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DATA_WIDTH-1:0]  cfg_start,
    input  logic [DATA_WIDTH-1:0]  cfg_stop,
    input  logic [DATA_WIDTH-1:0]  cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_loop,
    input  logic                   div_out,
    output logic [DATA_WIDTH-1:0]  psc,
    output logic                   psc_rst,
    output logic                   busy,
    output logic                   step_strobe,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, DWELL, ADVANCE, DONE} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  start_sh;
    logic [DATA_WIDTH-1:0]  stop_sh;
    logic [DATA_WIDTH-1:0]  step_sh;
    logic [DWELL_WIDTH-1:0] dwell_sh;
    logic                   loop_sh;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic                   div_prev;

    logic                   up;
    logic                   div_rise;
    logic [DWELL_WIDTH-1:0] cnt_inc;
    logic [DATA_WIDTH:0]    sum;
    logic [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH-1:0]  next_psc;

    assign up       = (start_sh <= stop_sh);
    assign div_rise = div_out & ~div_prev & ~psc_rst;
    assign cnt_inc  = dwell_cnt + DWELL_WIDTH'(1);
    assign sum      = {1'b0, psc} + {1'b0, step_sh};
    assign diff     = {1'b0, psc} - {1'b0, step_sh};

    // The extra bit catches carry/borrow so an overshoot clamps to stop instead of wrapping.
    always_comb begin
        next_psc = stop_sh;
        if (up) begin
            if (sum <= {1'b0, stop_sh})
                next_psc = sum[DATA_WIDTH-1:0];
        end else begin
            if (!diff[DATA_WIDTH] && (diff[DATA_WIDTH-1:0] >= stop_sh))
                next_psc = diff[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            psc         <= '0;
            psc_rst     <= 1'b0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            start_sh    <= '0;
            stop_sh     <= '0;
            step_sh     <= '0;
            dwell_sh    <= '0;
            loop_sh     <= 1'b0;
            dwell_cnt   <= '0;
            div_prev    <= 1'b0;
        end else begin
            psc_rst     <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            // While the divider is being reset its output is meaningless, so history restarts low.
            div_prev    <= psc_rst ? 1'b0 : div_out;

            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if ((cfg_step != '0) && (cfg_dwell != '0)) begin
                                start_sh  <= cfg_start;
                                stop_sh   <= cfg_stop;
                                step_sh   <= cfg_step;
                                dwell_sh  <= cfg_dwell;
                                loop_sh   <= cfg_loop;
                                psc       <= cfg_start;
                                psc_rst   <= 1'b1;
                                busy      <= 1'b1;
                                dwell_cnt <= '0;
                                state     <= DWELL;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    DWELL: begin
                        if (div_rise) begin
                            dwell_cnt <= cnt_inc;
                            if (cnt_inc == dwell_sh)
                                state <= ADVANCE;
                        end
                    end
                    ADVANCE: begin
                        if ((psc == stop_sh) && !loop_sh) begin
                            state <= DONE;
                        end else begin
                            psc         <= (psc == stop_sh) ? start_sh : next_psc;
                            psc_rst     <= 1'b1;
                            step_strobe <= 1'b1;
                            dwell_cnt   <= '0;
                            state       <= DWELL;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psc_sweep_ctrl.sv
// Testbench for psc_sweep_ctrl: emulates a divider driven by psc/psc_rst and compares each sweep
// against a value list computed arithmetically from the sweep rules.
module tb_psc_sweep_ctrl;

    localparam int DW = 8;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_start = '0;
    logic [DW-1:0] cfg_stop = '0;
    logic [DW-1:0] cfg_step = '0;
    logic [WW-1:0] cfg_dwell = '0;
    logic          cfg_loop = 1'b0;
    logic          div_out;
    logic [DW-1:0] psc;
    logic          psc_rst;
    logic          busy;
    logic          step_strobe;
    logic          done;
    logic          err;

    int assertions = 0;
    int failures = 0;

    int div_cnt = 0;
    int div_period;

    int seg_psc[$];
    int seg_edges[$];
    int exp_q[$];
    int rst_cnt = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int long_pulse = 0;
    int strobe_alone = 0;
    int mon_k;
    bit prev_div = 0, prev_rst_p = 0, prev_strobe = 0, prev_done = 0, prev_err = 0;

    psc_sweep_ctrl #(.DATA_WIDTH(DW), .DWELL_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .div_out(div_out),
        .psc(psc), .psc_rst(psc_rst), .busy(busy), .step_strobe(step_strobe),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Divider model: one-cycle output pulse every 3..6 cycles depending on psc, restarted by psc_rst.
    always_comb div_period = int'(psc % 4) + 3;
    assign div_out = (div_cnt == div_period - 1);

    always @(posedge clk) begin
        if (rst || psc_rst)
            div_cnt <= 0;
        else if (div_cnt >= div_period - 1)
            div_cnt <= 0;
        else
            div_cnt <= div_cnt + 1;
    end

    // Each psc_rst opens a new segment; rising divider edges seen while busy are tallied into it.
    always @(negedge clk) begin
        if (rst) begin
            prev_div = 0; prev_rst_p = 0; prev_strobe = 0; prev_done = 0; prev_err = 0;
        end else begin
            if (psc_rst) begin
                seg_psc.push_back(int'(psc));
                seg_edges.push_back(0);
                rst_cnt++;
                prev_div = 0;
            end else begin
                if (busy && div_out && !prev_div && seg_edges.size() > 0) begin
                    mon_k = seg_edges.size() - 1;
                    seg_edges[mon_k] = seg_edges[mon_k] + 1;
                end
                prev_div = div_out;
            end
            if (step_strobe) strobe_cnt++;
            if (step_strobe && !psc_rst) strobe_alone++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if ((psc_rst && prev_rst_p) || (step_strobe && prev_strobe) ||
                (done && prev_done) || (err && prev_err))
                long_pulse++;
            prev_rst_p = psc_rst; prev_strobe = step_strobe; prev_done = done; prev_err = err;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_monitor();
        seg_psc.delete();
        seg_edges.delete();
        rst_cnt = 0; strobe_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    // Reference sweep: walk from start toward stop in step-sized moves, clamping the final move.
    task automatic build_expected(input int s, input int p, input int st);
        int v;
        exp_q.delete();
        v = s;
        exp_q.push_back(v);
        while (v != p) begin
            if (s <= p) v = (v + st > p) ? p : v + st;
            else        v = (v - st < p) ? p : v - st;
            exp_q.push_back(v);
        end
    endtask

    task automatic apply_stimulus(input int s, input int p, input int st, input int d, input bit lp);
        @(posedge clk); #1;
        cfg_start = DW'(s); cfg_stop = DW'(p); cfg_step = DW'(st);
        cfg_dwell = WW'(d); cfg_loop = lp;
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({tag, "_timeout"}, 32'(n < 3000), 1);
        @(posedge clk); #1;
        check_output({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    task automatic run_sweep(input string tag, input int s, input int p, input int st, input int d,
                             input bit disturb);
        int n;
        build_expected(s, p, st);
        apply_stimulus(s, p, st, d, 1'b0);
        if (disturb) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1;
            cfg_start = DW'($urandom); cfg_stop = DW'($urandom);
            cfg_step = DW'($urandom); cfg_dwell = WW'($urandom_range(1, 9)); cfg_loop = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(tag);
        n = (seg_psc.size() < exp_q.size()) ? seg_psc.size() : exp_q.size();
        check_output({tag, "_nvals"}, 32'(seg_psc.size()), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_val%0d", tag, i), 32'(seg_psc[i]), 32'(exp_q[i]));
            check_output($sformatf("%s_dwell%0d", tag, i), 32'(seg_edges[i]), 32'(d));
        end
        check_output({tag, "_psc_rst"}, 32'(rst_cnt), 32'(exp_q.size()));
        check_output({tag, "_strobe"}, 32'(strobe_cnt), 32'(exp_q.size() - 1));
        check_output({tag, "_done"}, 32'(done_cnt), 1);
        check_output({tag, "_err"}, 32'(err_cnt), 0);
        check_output({tag, "_psc_final"}, 32'(psc), 32'(exp_q[exp_q.size() - 1]));
    endtask

    initial begin
        int n;
        int segs;
        int strobes;
        $display("[TB] psc_sweep_ctrl test starting");

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #2;
        check_output("rst_psc", 32'(psc), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_pulses", {28'd0, psc_rst, step_strobe, done, err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed sweeps: upward, downward with clamp, carry clamp.
        run_sweep("up_2_6", 2, 6, 2, 3, 1'b0);
        run_sweep("down_10_3", 10, 3, 4, 2, 1'b0);
        run_sweep("carry_250_255", 250, 255, 10, 1, 1'b0);

        // Random sweeps with mid-sweep start pulses and configuration changes.
        for (int r = 0; r < 6; r++)
            run_sweep($sformatf("rand%0d", r), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(16, 80)), int'($urandom_range(1, 4)), 1'b1);

        // Looping single-value sweep, terminated by abort.
        apply_stimulus(5, 5, 2, 1, 1'b1);
        repeat (60) @(posedge clk);
        #1;
        segs = seg_psc.size();
        strobes = strobe_cnt;
        check_output("loop_min_segs", 32'(segs >= 4), 1);
        check_output("loop_strobe", 32'(strobes), 32'(rst_cnt - 1));
        check_output("loop_no_done", 32'(done_cnt), 0);
        for (int i = 0; i < segs - 1; i++) begin
            check_output($sformatf("loop_val%0d", i), 32'(seg_psc[i]), 5);
            check_output($sformatf("loop_dwell%0d", i), 32'(seg_edges[i]), 1);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_output("abort_busy", 32'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        check_output("abort_no_done", 32'(done_cnt), 0);
        check_output("abort_psc_hold", 32'(psc), 5);
        check_output("abort_no_strobe", 32'(strobe_cnt - strobes), 32'(rst_cnt - segs));

        // Rejected starts: zero step, then zero dwell.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            cfg_start = 8'd40; cfg_stop = 8'd90; cfg_loop = 1'b0;
            cfg_step = (k == 0) ? 8'd0 : 8'd3;
            cfg_dwell = (k == 0) ? 16'd2 : 16'd0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check_output($sformatf("err%0d_pulse", k), 32'(err), 1);
            check_output($sformatf("err%0d_busy", k), 32'(busy), 0);
            check_output($sformatf("err%0d_psc", k), 32'(psc), 5);
            @(posedge clk); #1;
            check_output($sformatf("err%0d_clear", k), 32'(err), 0);
            check_output($sformatf("err%0d_idle", k), 32'(busy), 0);
        end

        // Reset in the middle of a dwell at psc=4.
        apply_stimulus(2, 6, 2, 3, 1'b0);
        n = 0;
        while (psc !== 8'd4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("midrst_reach4", 32'(n < 200), 1);
        #2 rst = 1'b1;
        #1;
        check_output("midrst_psc", 32'(psc), 0);
        check_output("midrst_busy", 32'(busy), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_output("midrst_no_done", 32'(done_cnt), 0);
        check_output("midrst_stays_idle", 32'(busy), 0);

        // Operation resumes with a fresh start.
        run_sweep("after_rst", 250, 255, 10, 2, 1'b0);

        check_output("pulse_width", 32'(long_pulse), 0);
        check_output("strobe_with_rst", 32'(strobe_alone), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
